rr_arbiter32: RTL
=================

Name: rr_arbiter32

Overview:
Round-robin arbiter that shares one 32-slot resource between 32 requesters.
- Winner is held as a registered 5-bit index; the one-hot select is produced by the team's 5-to-32 decoder (five_input_decoder).
- Sits between request lines and any datapath needing a single one-hot enable per cycle.
- Supports voluntary release and an optional forced-rotation timeout.

Parameters:
N_REQ, 32, number of requesters; fixed at 32 because the one-hot decode is 5-to-32.
IDX_W, 5, grant index width; log2(N_REQ).
HOLD_MAX, 15, maximum GRANT cycles before forced rotation when others are waiting; 0 disables the timeout.
CNT_W, 4, hold counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
req  input  32  request vector; bit i is requester i, level-sensitive.
release  input  1  current holder gives up its grant; sampled only in GRANT.
gnt_valid  output  1  a grant is active.
gnt_idx  output  5  index of the current holder; meaningful only when gnt_valid=1.
gnt_onehot  output  32  decode of gnt_idx ANDed with gnt_valid; all zero when no grant.
timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (asynchronous, immediate, also mid-grant):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0, timeout=0.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set bit of req, searching circularly from ptr upward (ptr, ptr+1, ..., 31, 0, ..., ptr-1).
  - On the next edge: gnt_idx=winner, gnt_valid=1, hold_cnt=0, go to GRANT.
  - Latency: req rising at edge k gives gnt_valid=1 after edge k+1.
- State GRANT, evaluated each edge, in priority order:
  1. release=1, or req[gnt_idx]=0: revoke; ptr=(gnt_idx+1) mod 32, go to IDLE.
  2. HOLD_MAX!=0, hold_cnt==HOLD_MAX-1, and any other req bit set: revoke; ptr=(gnt_idx+1) mod 32, timeout=1 for one cycle, go to IDLE.
  3. Otherwise stay in GRANT; hold_cnt increments, saturating at HOLD_MAX.
- The holder therefore keeps the grant for at most HOLD_MAX cycles.
- If no other requester is pending, the holder may keep the grant indefinitely; hold_cnt stays saturated.
- Revocation always costs one dead cycle with gnt_valid=0 in IDLE. Arbitration happens in IDLE, never back-to-back.
- Wrap-around: gnt_idx=31 sets ptr=0. ptr is 5 bits and wraps naturally.
- Simultaneous release and timeout: treated as a release; timeout stays 0.
- The same requester can win again after the dead cycle only if no other req bit is set between ptr and it.
- Outputs:
  - gnt_valid, gnt_idx and timeout are registered.
  - gnt_onehot is combinational from registered gnt_idx and gnt_valid, so it is glitch-free relative to the flops.
  - Exactly one bit of gnt_onehot is set while gnt_valid=1.
- req changes in IDLE take effect at the next edge. The bench may drive req freely and no synchronisation is assumed.

Decomposition:
- Shared package arb_pkg:
  - N_REQ=32, IDX_W=5.
  - State enum {IDLE, GRANT}, 1 bit.
  - Function next_idx(idx), returning (idx+1) mod 32.
- Sub-module rr_pick32, combinational:
  - Inputs: req[31:0], ptr[4:0]. Outputs: any, win_idx[4:0].
  - Implementation: rotate req right by ptr, priority-encode the lowest set bit, add ptr mod 32.
- The one-hot output uses one five_input_decoder instance fed by gnt_idx; its output is masked with gnt_valid.

Test Plan:
- Reset mid-grant:
  - Stimulus: grant requester 9, then assert rst asynchronously between edges.
  - Required: gnt_valid, gnt_onehot and timeout go to 0 immediately. After release of reset with req=0x200, grant goes to 9 again (ptr was reset to 0).
- Single requester:
  - Stimulus: rst, then req=0x0000_0008.
  - Required: one edge later gnt_valid=1, gnt_idx=3, gnt_onehot=0x0000_0008, held while req[3]=1 with no timeout.
- Rotation with wrap:
  - Stimulus: req=0x8000_0001 held, release pulsed each time a grant appears.
  - Required: grant sequence 0, 31, 0, 31. One dead cycle between grants. After idx 31, ptr=0.
- Timeout:
  - Stimulus: HOLD_MAX=15, req=0x0000_0030 held, no release.
  - Required: idx 4 is held for 15 cycles, then timeout pulses 1 cycle, a dead cycle follows, then gnt_idx=5.
  - Required: with req=0x10 only, idx 4 is never revoked.
- Simultaneous release and timeout:
  - Stimulus: release asserted on the cycle hold_cnt reaches 14 with other requests pending.
  - Required: revoke, timeout=0, ptr advances.
- Fairness sweep:
  - Stimulus: req=0xFFFF_FFFF for 64 grants with release after 2 cycles each.
  - Required: gnt_idx=0,1,...,31,0,...; each index granted exactly twice; gnt_onehot==(1<<gnt_idx) whenever gnt_valid=1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and index helper for the 32-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned N_REQ = 32;
   localparam int unsigned IDX_W = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Circular successor of a requester index; 5-bit arithmetic wraps 31 to 0.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/five_input_decoder.sv
// 5-to-32 binary to one-hot decoder.
module five_input_decoder (
   input  logic [4:0]  sel,
   output logic [31:0] y
);

   always_comb begin
      y = 32'(1) << sel;
   end

endmodule

// File: rtl/rr_pick32.sv
// Combinational round-robin pick: first set request at or circularly above ptr.
module rr_pick32
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] win_idx
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] off;

   // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the rotation.
   always_comb begin
      rot = N_REQ'({req, req} >> ptr);
      off = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDX_W'(i);
         end
      end
      any     = |req;
      win_idx = off + ptr;
   end

endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter for 32 requesters with voluntary release and forced-rotation timeout.
module rr_arbiter32
   import arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             release_grant,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic             timeout
);

   arb_state_e       state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic [N_REQ-1:0] idx_dec;
   logic             holder_req;
   logic             others_pending;
   logic             hold_expired;

   rr_pick32 u_pick (
      .req     (req),
      .ptr     (ptr),
      .any     (pick_any),
      .win_idx (pick_idx)
   );

   five_input_decoder u_dec (
      .sel (gnt_idx),
      .y   (idx_dec)
   );

   // The >= keeps the holder bounded even after the counter has saturated.
   always_comb begin
      holder_req     = req[gnt_idx];
      others_pending = |(req & ~idx_dec);
      hold_expired   = (HOLD_MAX != 0) && (hold_cnt >= CNT_W'(HOLD_MAX - 1));
      gnt_onehot     = idx_dec & {N_REQ{gnt_valid}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state     <= GRANT;
                  gnt_idx   <= pick_idx;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
               end
            end
            GRANT: begin
               if (release_grant || !holder_req) begin
                  state     <= IDLE;
                  gnt_valid <= 1'b0;
                  ptr       <= next_idx(gnt_idx);
               end else if (hold_expired && others_pending) begin
                  state     <= IDLE;
                  gnt_valid <= 1'b0;
                  ptr       <= next_idx(gnt_idx);
                  timeout   <= 1'b1;
               end else if (hold_cnt != CNT_W'(HOLD_MAX)) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               state     <= IDLE;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
